// File: rtl/farbfeld_writer.sv
// farbfeld stream writer: magic, big-endian width/height, then RGBA16 pixels in raster order.
// Build option FARBFELD_ALPHA_IN_EN adds an alpha input; otherwise alpha is ALPHA_CONST.
module farbfeld_writer #(
  parameter logic [15:0] ALPHA_CONST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] width,
  input  logic [31:0] height,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] red,
  input  logic [15:0] green,
  input  logic [15:0] blue,
`ifdef FARBFELD_ALPHA_IN_EN
  input  logic [15:0] alpha,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for start
  // MAGIC  | sending "farbfeld"
  // WIDTH  | sending width, MSB first
  // HEIGHT | sending height, MSB first
  // PIXEL  | refilling / draining the one-pixel buffer
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAGIC  = 3'd1,
    WIDTH  = 3'd2,
    HEIGHT = 3'd3,
    PIXEL  = 3'd4
  } state_t;

  localparam logic [63:0] MAGIC_BYTES = 64'h6661726266656C64;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;
  logic [31:0] r_width;
  logic [31:0] r_height;
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic [63:0] r_buf;
  logic        r_full;
  logic        r_done;

  logic        w_xfer;
  logic        w_pix_xfer;
  logic        w_field_end;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_empty_img;
  logic [15:0] w_alpha;
  logic [5:0]  w_sel64;
  logic [4:0]  w_sel32;

`ifdef FARBFELD_ALPHA_IN_EN
  assign w_alpha = alpha;
`else
  assign w_alpha = ALPHA_CONST;
`endif

  // byte 0 is the most significant one; ~idx gives the byte position from the LSB end
  assign w_sel64     = {~r_idx, 3'b000};
  assign w_sel32     = {~r_idx[1:0], 3'b000};
  assign w_xfer      = out_valid && out_ready;
  assign w_pix_xfer  = pix_valid && pix_ready;
  assign w_last_col  = (r_col == r_width - 32'd1);
  assign w_last_row  = (r_row == r_height - 32'd1);
  assign w_empty_img = (r_width == 32'd0) || (r_height == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_field_end = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    pix_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = MAGIC;
      end
      MAGIC: begin
        out_valid   = 1'b1;
        out_data    = MAGIC_BYTES[w_sel64 +: 8];
        w_field_end = (r_idx == 3'd7);
        if (w_xfer && w_field_end) w_next = WIDTH;
      end
      WIDTH: begin
        out_valid   = 1'b1;
        out_data    = r_width[w_sel32 +: 8];
        w_field_end = (r_idx[1:0] == 2'd3);
        if (w_xfer && w_field_end) w_next = HEIGHT;
      end
      HEIGHT: begin
        out_valid   = 1'b1;
        out_data    = r_height[w_sel32 +: 8];
        w_field_end = (r_idx[1:0] == 2'd3);
        if (w_xfer && w_field_end) w_next = w_empty_img ? IDLE : PIXEL;
      end
      PIXEL: begin
        out_valid   = r_full;
        out_data    = r_full ? r_buf[w_sel64 +: 8] : 8'h00;
        pix_ready   = !r_full;
        w_field_end = (r_idx == 3'd7);
        if (w_xfer && w_field_end && w_last_col && w_last_row) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= 3'd0;
      r_width  <= 32'd0;
      r_height <= 32'd0;
      r_row    <= 32'd0;
      r_col    <= 32'd0;
      r_buf    <= 64'd0;
      r_full   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state != IDLE) && (w_next == IDLE);
      if (r_state == IDLE && start) begin
        r_width  <= width;
        r_height <= height;
        r_row    <= 32'd0;
        r_col    <= 32'd0;
        r_idx    <= 3'd0;
        r_full   <= 1'b0;
      end
      if (w_xfer) r_idx <= w_field_end ? 3'd0 : r_idx + 3'd1;
      if (w_pix_xfer) begin
        r_buf  <= {red, green, blue, w_alpha};
        r_full <= 1'b1;
      end
      // last byte of a pixel frees the buffer and advances the raster position
      if (r_state == PIXEL && w_xfer && w_field_end) begin
        r_full <= 1'b0;
        if (w_last_col) begin
          r_col <= 32'd0;
          r_row <= r_row + 32'd1;
        end else begin
          r_col <= r_col + 32'd1;
        end
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_farbfeld_writer.sv
// Directed bench for farbfeld_writer; a second instance with ALPHA_CONST=16'h8000 runs in lockstep.
module tb_farbfeld_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] width, height;
  logic        pix_valid, out_ready;
  logic [15:0] red, green, blue;
  logic        pix_ready, out_valid, busy, done;
  logic [7:0]  out_data;
  logic [31:0] row, col;
  logic        pix_ready2, out_valid2, busy2, done2;
  logic [7:0]  out_data2;
  logic [31:0] row2, col2;
`ifdef FARBFELD_ALPHA_IN_EN
  logic [15:0] alpha = 16'h0102;
  localparam logic [15:0] EXP_A1 = 16'h0102;
  localparam logic [15:0] EXP_A2 = 16'h0102;
`else
  localparam logic [15:0] EXP_A1 = 16'hFFFF;
  localparam logic [15:0] EXP_A2 = 16'h8000;
`endif

  always #5 clk = ~clk;

  farbfeld_writer dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .red(red), .green(green), .blue(blue),
`ifdef FARBFELD_ALPHA_IN_EN
    .alpha(alpha),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .row(row), .col(col), .busy(busy), .done(done));

  farbfeld_writer #(.ALPHA_CONST(16'h8000)) dut2 (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready2), .red(red), .green(green), .blue(blue),
`ifdef FARBFELD_ALPHA_IN_EN
    .alpha(alpha),
`endif
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .row(row2), .col(col2), .busy(busy2), .done(done2));

  int checks = 0;
  int failures = 0;
  int done_cnt;
  bit pr_seen;
  logic [7:0]  got_q[$], got2_q[$], exp_q[$], exp2_q[$];
  logic [47:0] px_q[$];
  logic [63:0] rc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    got_q.delete(); got2_q.delete(); exp_q.delete(); exp2_q.delete();
    px_q.delete(); rc_q.delete();
    done_cnt = 0;
    pr_seen  = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(w[i*8 +: 8]);
      exp2_q.push_back(w[i*8 +: 8]);
    end
  endtask

  task automatic push_hdr(input logic [31:0] w, input logic [31:0] h);
    logic [63:0] m;
    m = 64'h6661726266656C64;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(m[i*8 +: 8]);
      exp2_q.push_back(m[i*8 +: 8]);
    end
    push_word(w);
    push_word(h);
  endtask

  task automatic push_px(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    logic [63:0] p1, p2;
    p1 = {r, g, b, EXP_A1};
    p2 = {r, g, b, EXP_A2};
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(p1[i*8 +: 8]);
      exp2_q.push_back(p2[i*8 +: 8]);
    end
    px_q.push_back({r, g, b});
  endtask

  task automatic cmp_streams(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < got2_q.size() && i < exp2_q.size(); i++)
      chk($sformatf("%s_c8000_b%0d", tag, i), got2_q[i], exp2_q[i]);
  endtask

  task automatic do_start(input logic [31:0] w, input logic [31:0] h);
    width = w; height = h; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
  endtask

  // Drive sink/source for up to budget cycles until n bytes have been accepted.
  task automatic run(input int n, input bit toggle, input int budget);
    int got = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = 8'h00;
    bit pop;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      pix_valid = (px_q.size() > 0);
      if (pix_valid) {red, green, blue} = px_q[0];
      #1;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_d);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      pop        = pix_valid && pix_ready;
      if (pix_ready) pr_seen = 1;
      if (pop) rc_q.push_back({row, col});
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got2_q.push_back(out_data2);
        got++;
      end
      @(posedge clk); #1;
      if (pop) void'(px_q.pop_front());
      if (done) done_cnt++;
    end
    chk("run_byte_count", got, n);
    pix_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; width = 0; height = 0;
    pix_valid = 1'b0; out_ready = 1'b0; red = 0; green = 0; blue = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_rowcol", {row, col}, 64'd0);
    chk("rst_out_data", out_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1x1 image, sink always ready
    clear_all();
    do_start(1, 1);
    chk("t1_first_valid", out_valid, 1'b1);
    chk("t1_first_f", out_data, 8'h66);
    chk("t1_busy", busy, 1'b1);
    push_hdr(1, 1);
    push_px(16'h1234, 16'h5678, 16'h9ABC);
    run(24, 0, 200);
    idle(3);
    cmp_streams("t1");
    chk("t1_done_once", done_cnt, 1);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_rowcol_end", {row, col}, {32'd1, 32'd0});

    // 2x2 image with a stalling sink
    clear_all();
    do_start(2, 2);
    push_hdr(2, 2);
    push_px(16'h1111, 16'h2222, 16'h3333);
    push_px(16'hA0A1, 16'hB0B1, 16'hC0C1);
    push_px(16'h0F0E, 16'h0D0C, 16'h0B0A);
    push_px(16'hFEDC, 16'hBA98, 16'h7654);
    run(48, 1, 400);
    idle(3);
    cmp_streams("t2");
    chk("t2_px_count", rc_q.size(), 4);
    if (rc_q.size() == 4) begin
      chk("t2_rc0", rc_q[0], {32'd0, 32'd0});
      chk("t2_rc1", rc_q[1], {32'd0, 32'd1});
      chk("t2_rc2", rc_q[2], {32'd1, 32'd0});
      chk("t2_rc3", rc_q[3], {32'd1, 32'd1});
    end
    chk("t2_rowcol_end", {row, col}, {32'd2, 32'd0});
    chk("t2_done_once", done_cnt, 1);

    // zero width: header only
    clear_all();
    do_start(0, 5);
    push_hdr(0, 5);
    run(16, 0, 100);
    idle(4);
    cmp_streams("t3");
    chk("t3_no_pix_ready", pr_seen, 1'b0);
    chk("t3_done_once", done_cnt, 1);
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_idle_valid", out_valid, 1'b0);

    // second start during MAGIC is ignored
    clear_all();
    do_start(3, 1);
    width = 9; height = 9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_hdr(3, 1);
    push_px(16'h0001, 16'h0002, 16'h0003);
    push_px(16'h0004, 16'h0005, 16'h0006);
    push_px(16'h0007, 16'h0008, 16'h0009);
    run(40, 0, 300);
    idle(3);
    cmp_streams("t4");
    chk("t4_done_once", done_cnt, 1);
    chk("t4_rowcol_end", {row, col}, {32'd1, 32'd0});

    // reset in the middle of pixel byte 3
    clear_all();
    do_start(1, 1);
    push_hdr(1, 1);
    push_px(16'hDEAD, 16'hBEEF, 16'hCAFE);
    run(19, 0, 200);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_rowcol", {row, col}, 64'd0);
    chk("t5_rst_pix_ready", pix_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_all();
    do_start(1, 1);
    chk("t5_restart_f", out_data, 8'h66);
    chk("t5_restart_valid", out_valid, 1'b1);
    push_hdr(1, 1);
    push_px(16'h4321, 16'h8765, 16'hCBA9);
    run(24, 0, 200);
    idle(3);
    cmp_streams("t5");
    chk("t5_done_once", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
